// File: rtl/display_update_ctrl_pkg.sv
// Shared definitions for the display update sequencer: FSM encoding and
// elaboration-time helpers for counter widths and the saturation limit.
package display_update_ctrl_pkg;

    typedef enum logic [1:0] {
        st_idle,
        st_shift,
        st_commit,
        st_hold
    } state_t;

    // Smallest r such that 2^r >= x.
    function automatic int unsigned clog2(input longint unsigned x);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < x) begin
            r++;
        end
        return r;
    endfunction

    // 10^n - 1, the largest value n decimal digits can show.
    function automatic longint unsigned max_decimal(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/display_update_ctrl_if.sv
// Value handshake and display-side outputs of the update sequencer.
interface display_update_ctrl_if #(
    parameter int unsigned NUM_DISPLAYS = 6,
    parameter int unsigned VALUE_WIDTH  = 20
);
    logic [VALUE_WIDTH-1:0]    value_in;
    logic                      value_valid;
    logic                      value_ready;
    logic [NUM_DISPLAYS*4-1:0] bcd_value;
    logic                      update_done;
    logic                      overflow;
    logic                      busy;

    modport master (
        output value_in,
        output value_valid,
        input  value_ready,
        input  bcd_value,
        input  update_done,
        input  overflow,
        input  busy
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output value_ready,
        output bcd_value,
        output update_done,
        output overflow,
        output busy
    );

endinterface

// File: rtl/display_update_ctrl_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more.
module display_update_ctrl_bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/display_update_ctrl.sv
// Binary-to-BCD update sequencer: accepts a value, converts it one bit per cycle,
// commits all digits at once and then holds off further accepts for HOLD_CYCLES.
module display_update_ctrl
    import display_update_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DISPLAYS = 6,
    parameter int unsigned VALUE_WIDTH  = 20,
    parameter int unsigned HOLD_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    display_update_ctrl_if.slave bus
);

    localparam int unsigned ACC_W    = NUM_DISPLAYS * 4;
    localparam int unsigned ITER_W   = clog2(64'(VALUE_WIDTH) + 64'd1);
    localparam int unsigned HOLD_LOG = clog2(64'(HOLD_CYCLES) + 64'd1);
    localparam int unsigned HOLD_W   = (HOLD_LOG > 0) ? HOLD_LOG : 1;
    localparam longint unsigned MAX_DEC = max_decimal(NUM_DISPLAYS);
    localparam int unsigned DEC_W    = clog2(MAX_DEC + 64'd1);
    localparam int unsigned CMP_W    = (DEC_W > VALUE_WIDTH) ? DEC_W : VALUE_WIDTH;

    localparam logic [CMP_W-1:0]       MAX_CMP   = CMP_W'(MAX_DEC);
    localparam logic [VALUE_WIDTH-1:0] MAX_OP    = VALUE_WIDTH'(MAX_DEC);
    localparam logic [ITER_W-1:0]      ITER_LAST = ITER_W'(VALUE_WIDTH - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LAST =
        HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    state_t                   state_q;
    logic [VALUE_WIDTH-1:0]   op_q;
    logic [ACC_W-1:0]         acc_q;
    logic                     pend_ovf_q;
    logic [ITER_W-1:0]        iter_q;
    logic [HOLD_W-1:0]        hold_q;
    logic [ACC_W-1:0]         bcd_q;
    logic                     ovf_q;
    logic                     done_q;
    logic                     busy_q;
    logic                     ready_q;

    logic [ACC_W-1:0]             acc_adj;
    logic [ACC_W+VALUE_WIDTH-1:0] shifted;
    logic [CMP_W-1:0]             value_ext;
    logic                         too_big;
    logic                         accept;

    for (genvar g = 0; g < NUM_DISPLAYS; g++) begin : g_add3
        display_update_ctrl_bcd_add3 u_add3 (
            .digit    (acc_q[g*4 +: 4]),
            .adjusted (acc_adj[g*4 +: 4])
        );
    end

    assign shifted   = {acc_adj, op_q} << 1;
    assign value_ext = CMP_W'(bus.value_in);
    // Never true when the input range cannot exceed MAX_DEC, so overflow folds to 0.
    assign too_big   = value_ext > MAX_CMP;
    assign accept    = bus.value_valid & ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= st_idle;
            op_q       <= '0;
            acc_q      <= '0;
            pend_ovf_q <= 1'b0;
            iter_q     <= '0;
            hold_q     <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                st_idle: begin
                    if (accept) begin
                        state_q    <= st_shift;
                        op_q       <= too_big ? MAX_OP : bus.value_in;
                        pend_ovf_q <= too_big;
                        acc_q      <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                st_shift: begin
                    acc_q  <= shifted[ACC_W+VALUE_WIDTH-1:VALUE_WIDTH];
                    op_q   <= shifted[VALUE_WIDTH-1:0];
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == ITER_LAST) begin
                        state_q <= st_commit;
                    end
                end
                st_commit: begin
                    bcd_q  <= acc_q;
                    ovf_q  <= pend_ovf_q;
                    done_q <= 1'b1;
                    hold_q <= '0;
                    if (HOLD_CYCLES > 0) begin
                        state_q <= st_hold;
                    end else begin
                        state_q <= st_idle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                st_hold: begin
                    hold_q <= hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_q <= st_idle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.value_ready = ready_q;
    assign bus.bcd_value   = bcd_q;
    assign bus.update_done = done_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed bench for display_update_ctrl: one instance with a 4-cycle hold-off,
// one with none.
module tb_display_update_ctrl;

    logic clk;
    logic rst;
    logic rst0;
    int   checks;
    int   errors;

    display_update_ctrl_if #(.NUM_DISPLAYS(6), .VALUE_WIDTH(20)) bus ();
    display_update_ctrl_if #(.NUM_DISPLAYS(6), .VALUE_WIDTH(20)) bus0 ();

    display_update_ctrl #(
        .NUM_DISPLAYS (6),
        .VALUE_WIDTH  (20),
        .HOLD_CYCLES  (4)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    display_update_ctrl #(
        .NUM_DISPLAYS (6),
        .VALUE_WIDTH  (20),
        .HOLD_CYCLES  (0)
    ) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] v;
        logic [23:0] b;
        logic        o;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.value_ready && n < 200) begin
            tick();
            n++;
        end
        check({name, " ready_wait"}, 64'(bus.value_ready), 64'd1);
    endtask

    task automatic wait_ready0(input string name);
        int n;
        n = 0;
        while (!bus0.value_ready && n < 200) begin
            tick();
            n++;
        end
        check({name, " ready_wait"}, 64'(bus0.value_ready), 64'd1);
    endtask

    // One full transaction on the HOLD_CYCLES=4 instance, checking timing end to end.
    task automatic apply(input logic [19:0] v, input logic [23:0] eb, input logic eo,
                         input string name);
        logic [23:0] prev;
        bit          spur;
        int          gap;
        wait_ready(name);
        prev = bus.bcd_value;
        bus.value_in    = v;
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        check({name, " ready_drop"}, 64'(bus.value_ready), 64'd0);
        check({name, " busy_e0"}, 64'(bus.busy), 64'd1);
        spur = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.update_done) spur = 1'b1;
        end
        check({name, " early_done"}, 64'(spur), 64'd0);
        check({name, " bcd_stable"}, 64'(bus.bcd_value), 64'(prev));
        tick();
        check({name, " done"}, 64'(bus.update_done), 64'd1);
        check({name, " bcd"}, 64'(bus.bcd_value), 64'(eb));
        check({name, " ovf"}, 64'(bus.overflow), 64'(eo));
        tick();
        check({name, " done_pulse"}, 64'(bus.update_done), 64'd0);
        check({name, " busy_hold"}, 64'(bus.busy), 64'd1);
        gap = 0;
        while (!bus.value_ready && gap < 50) begin
            tick();
            gap++;
        end
        check({name, " hold_gap"}, 64'(gap), 64'd3);
        check({name, " busy_idle"}, 64'(bus.busy), 64'd0);
        check({name, " bcd_keep"}, 64'(bus.bcd_value), 64'(eb));
    endtask

    initial begin
        int acc_edges [$];
        bit pre;
        int dones;

        checks = 0;
        errors = 0;
        vecs[0]  = '{20'd123456,  24'h123456, 1'b0};
        vecs[1]  = '{20'd1000000, 24'h999999, 1'b1};
        vecs[2]  = '{20'd42,      24'h000042, 1'b0};
        vecs[3]  = '{20'd0,       24'h000000, 1'b0};
        vecs[4]  = '{20'd999999,  24'h999999, 1'b0};
        vecs[5]  = '{20'hFFFFF,   24'h999999, 1'b1};
        vecs[6]  = '{20'd7,       24'h000007, 1'b0};
        vecs[7]  = '{20'd100000,  24'h100000, 1'b0};
        vecs[8]  = '{20'd90909,   24'h090909, 1'b0};
        vecs[9]  = '{20'd500005,  24'h500005, 1'b0};
        vecs[10] = '{20'd65535,   24'h065535, 1'b0};

        rst = 1'b1;
        rst0 = 1'b1;
        bus.value_in = '0;
        bus.value_valid = 1'b0;
        bus0.value_in = '0;
        bus0.value_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst bcd", 64'(bus.bcd_value), 64'd0);
        check("rst ovf", 64'(bus.overflow), 64'd0);
        check("rst done", 64'(bus.update_done), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst ready", 64'(bus.value_ready), 64'd0);
        rst = 1'b0;
        rst0 = 1'b0;
        tick();
        check("post_rst ready", 64'(bus.value_ready), 64'd1);
        check("post_rst ready0", 64'(bus0.value_ready), 64'd1);

        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].v, vecs[i].b, vecs[i].o, $sformatf("vec%0d", i));
        end

        // valid held high; value_in wanders while not ready
        bus.value_in = 20'd314159;
        for (int c = 0; c <= 74; c++) begin
            if (c >= 5 && c < 23) bus.value_in = 20'd777777;
            else if (c >= 23 && c < 31) bus.value_in = 20'd271828;
            else if (c >= 31 && c < 49) bus.value_in = 20'd999;
            else if (c >= 49) bus.value_in = 20'd161803;
            bus.value_valid = (c <= 52);
            pre = bus.value_ready && bus.value_valid;
            tick();
            if (pre) acc_edges.push_back(c);
            if (c == 21) check("held A", 64'(bus.bcd_value), 64'h314159);
            if (c == 47) check("held B", 64'(bus.bcd_value), 64'h271828);
            if (c == 73) check("held D", 64'(bus.bcd_value), 64'h161803);
        end
        check("held accepts", 64'(acc_edges.size()), 64'd3);
        foreach (acc_edges[i]) check($sformatf("held edge%0d", i), 64'(acc_edges[i]), 64'(i * 26));

        // Reset during SHIFT
        wait_ready("midrst");
        bus.value_in = 20'd888888;
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("midrst bcd", 64'(bus.bcd_value), 64'd0);
        check("midrst ovf", 64'(bus.overflow), 64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst ready", 64'(bus.value_ready), 64'd0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.update_done) dones++;
        end
        check("midrst no_done", 64'(dones), 64'd0);
        check("midrst bcd_zero", 64'(bus.bcd_value), 64'd0);
        apply(20'd555, 24'h000555, 1'b0, "after_rst");

        // HOLD_CYCLES = 0: back-to-back accepts every 22 cycles
        acc_edges.delete();
        wait_ready0("h0");
        bus0.value_in = 20'd246810;
        for (int c = 0; c <= 66; c++) begin
            if (c >= 5 && c < 22) bus0.value_in = 20'd1;
            else if (c >= 22 && c < 27) bus0.value_in = 20'd135791;
            else if (c >= 27 && c < 44) bus0.value_in = 20'd2;
            else if (c >= 44) bus0.value_in = 20'd1048000;
            bus0.value_valid = (c <= 44);
            pre = bus0.value_ready && bus0.value_valid;
            tick();
            if (pre) acc_edges.push_back(c);
            if (c == 21) check("h0 X", 64'(bus0.bcd_value), 64'h246810);
            if (c == 21) check("h0 X done", 64'(bus0.update_done), 64'd1);
            if (c == 43) check("h0 Y", 64'(bus0.bcd_value), 64'h135791);
            if (c == 65) check("h0 Z", 64'(bus0.bcd_value), 64'h999999);
            if (c == 65) check("h0 Z ovf", 64'(bus0.overflow), 64'd1);
        end
        check("h0 accepts", 64'(acc_edges.size()), 64'd3);
        foreach (acc_edges[i]) check($sformatf("h0 edge%0d", i), 64'(acc_edges[i]), 64'(i * 22));

        // HOLD_CYCLES = 0: reset during SHIFT, then a clean conversion
        wait_ready0("h0 midrst");
        bus0.value_in = 20'd123;
        bus0.value_valid = 1'b1;
        tick();
        bus0.value_valid = 1'b0;
        repeat (9) tick();
        rst0 = 1'b1;
        tick();
        check("h0 midrst bcd", 64'(bus0.bcd_value), 64'd0);
        check("h0 midrst ovf", 64'(bus0.overflow), 64'd0);
        check("h0 midrst busy", 64'(bus0.busy), 64'd0);
        rst0 = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus0.update_done) dones++;
        end
        check("h0 midrst no_done", 64'(dones), 64'd0);
        wait_ready0("h0 after");
        bus0.value_in = 20'd4321;
        bus0.value_valid = 1'b1;
        tick();
        bus0.value_valid = 1'b0;
        repeat (20) tick();
        check("h0 after pre_done", 64'(bus0.update_done), 64'd0);
        tick();
        check("h0 after done", 64'(bus0.update_done), 64'd1);
        check("h0 after bcd", 64'(bus0.bcd_value), 64'h004321);
        tick();
        check("h0 after ready", 64'(bus0.value_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
